// File: rtl/gpu_ctrl_pkg.sv
// gpu_ctrl_pkg: types and constants shared by the Filter-GPU control blocks,
// including the kernel encoding that imem and decode also use.
package gpu_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        RUN,
        DONE
    } kfs_state_t;

    localparam int INSTR_BYTES = 4;

    typedef logic [1:0] kernel_t;

    // Byte address of the final word of a program of prog_len instructions.
    function automatic logic [31:0] last_pc(input int prog_len);
        return 32'((prog_len - 1) * INSTR_BYTES);
    endfunction

endpackage

// File: rtl/kernel_fetch_seq_wrap_counter.sv
// wrap_counter: up-counter with clear, hold, fixed step and wrap-to-zero at LIMIT.
// wrap_o strobes in the enabled cycle that moves the count from LIMIT back to zero.
module wrap_counter #(
    parameter int unsigned    W     = 32,
    parameter logic [W-1:0]   STEP  = W'(4),
    parameter logic [W-1:0]   LIMIT = '0
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         clr_i,
    input  logic         en_i,
    output logic [W-1:0] cnt_o,
    output logic         wrap_o
);

    logic [W-1:0] cnt_q, cnt_d;

    assign wrap_o = en_i && (cnt_q == LIMIT);
    assign cnt_o  = cnt_q;

    // Clear wins over counting so an abort can never be overridden by a wrap.
    always_comb begin
        cnt_d = clr_i ? '0 : !en_i ? cnt_q : wrap_o ? '0 : cnt_q + STEP;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) cnt_q <= '0;
        else         cnt_q <= cnt_d;
    end

endmodule

// File: rtl/kernel_fetch_seq.sv
// kernel_fetch_seq: drives the instruction-memory PC through a kernel program once
// per pixel for a latched pixel count, honouring stall and abort.
module kernel_fetch_seq
    import gpu_ctrl_pkg::*;
#(
    parameter int unsigned PROG_LEN = 9,
    parameter int unsigned PIX_W    = 20
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             start_i,
    input  kernel_t          kernel_sel_i,
    input  logic [PIX_W-1:0] num_pixels_i,
    input  logic             stall_i,
    input  logic             abort_i,
    output logic [31:0]      pc_o,
    output kernel_t          kernel_o,
    output logic             fetch_valid_o,
    output logic             last_instr_o,
    output logic [PIX_W-1:0] pixel_idx_o,
    output logic             busy_o,
    output logic             done_o
);

    localparam logic [31:0] LAST_PC = last_pc(int'(PROG_LEN));

    kfs_state_t       state_q, state_d;
    kernel_t          kernel_q, kernel_d;
    logic [PIX_W-1:0] count_q, count_d;
    logic [PIX_W-1:0] pix_q, pix_d;
    logic             pc_clr, pc_en, pc_wrap, last_pix;

    wrap_counter #(
        .W     (32),
        .STEP  (32'(INSTR_BYTES)),
        .LIMIT (LAST_PC)
    ) u_pc (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .clr_i  (pc_clr),
        .en_i   (pc_en),
        .cnt_o  (pc_o),
        .wrap_o (pc_wrap)
    );

    always_comb begin
        state_d       = state_q;
        kernel_d      = kernel_q;
        count_d       = count_q;
        pix_d         = pix_q;
        pc_clr        = 1'b0;
        fetch_valid_o = (state_q == RUN) && !stall_i;
        pc_en         = fetch_valid_o && !abort_i;
        last_pix      = (pix_q + PIX_W'(1)) == count_q;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d  = LOAD;
                    kernel_d = kernel_sel_i;
                    count_d  = num_pixels_i;
                    pix_d    = '0;
                    pc_clr   = 1'b1;
                end
            end
            LOAD:    state_d = (count_q == '0) ? DONE : RUN;
            RUN: begin
                if (pc_wrap) begin
                    if (last_pix) state_d = DONE;
                    else          pix_d   = pix_q + PIX_W'(1);
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // Abort overrides everything above, including a pending wrap or completion.
        if (abort_i && state_q != IDLE) begin
            state_d = IDLE;
            pc_clr  = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= IDLE;
            kernel_q <= '0;
            count_q  <= '0;
            pix_q    <= '0;
        end else begin
            state_q  <= state_d;
            kernel_q <= kernel_d;
            count_q  <= count_d;
            pix_q    <= pix_d;
        end
    end

    assign last_instr_o = fetch_valid_o && (pc_o == LAST_PC);
    assign kernel_o     = kernel_q;
    assign pixel_idx_o  = pix_q;
    assign busy_o       = state_q != IDLE;
    assign done_o       = state_q == DONE;

endmodule
